// File: rtl/button_event_scheduler_pkg.sv
// Shared types and helpers for the button event scheduler.
// Holds the FSM encoding, counter limits and the round-robin pointer step.
package button_scheduler_pkg;

   typedef enum logic {IDLE, OFFER} sched_state_t;

   localparam int unsigned CNT_WIDTH_DEF_C = 8;

   // All-ones seed; truncating it to the counter width gives the saturation value.
   localparam int unsigned CNT_MAX_C = 32'hFFFF_FFFF;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/button_event_scheduler_rr_arbiter.sv
// Combinational rotate-priority selector.
// Picks the first requesting index at or above rr_ptr, wrapping around.
module button_rr_arbiter #(
   parameter int unsigned N_P    = 4,
   parameter int unsigned ID_W_P = 2
) (
   input  logic [N_P-1:0]    req,
   input  logic [ID_W_P-1:0] rr_ptr,
   output logic              gnt_valid,
   output logic [ID_W_P-1:0] gnt_id
);

   logic [ID_W_P-1:0] idx;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int unsigned k = 0; k < N_P; k++) begin
         idx = ID_W_P'((32'(rr_ptr) + k) % N_P);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx;
         end
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Turns button-core toggles into coalesced press events on a valid/ready stream,
// with round-robin fairness, per-button masking and sticky overflow flags.
module button_event_scheduler
   import button_scheduler_pkg::*;
#(
   parameter int unsigned NR_OF_BUTTONS_P = 4,
   parameter int unsigned CNT_WIDTH_P     = CNT_WIDTH_DEF_C,
   parameter int unsigned ID_WIDTH_P      = $clog2(NR_OF_BUTTONS_P)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NR_OF_BUTTONS_P-1:0] btn_tgl,
   input  logic [NR_OF_BUTTONS_P-1:0] btn_mask,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [ID_WIDTH_P-1:0]      evt_id,
   output logic [CNT_WIDTH_P-1:0]     evt_count,
   output logic [NR_OF_BUTTONS_P-1:0] ovf_flags,
   input  logic [NR_OF_BUTTONS_P-1:0] ovf_clr,
   output logic                       irq
);

   localparam logic [CNT_WIDTH_P-1:0] CNT_SAT = CNT_WIDTH_P'(CNT_MAX_C);

   sched_state_t state, state_nxt;

   logic [NR_OF_BUTTONS_P-1:0] tgl_q;
   logic [NR_OF_BUTTONS_P-1:0] press;
   logic [NR_OF_BUTTONS_P-1:0] req;
   logic [NR_OF_BUTTONS_P-1:0] take;
   logic [NR_OF_BUTTONS_P-1:0] sat_hit;
   logic [CNT_WIDTH_P-1:0]     cnt [NR_OF_BUTTONS_P];
   logic [ID_WIDTH_P-1:0]      rr_ptr;
   logic [ID_WIDTH_P-1:0]      gnt_id;
   logic                       gnt_valid;
   logic                       grant;
   logic                       handshake;

   // tgl_q follows masked buttons too, so unmasking never yields a phantom press.
   assign press = (btn_tgl ^ tgl_q) & ~btn_mask;

   always_comb begin
      req     = '0;
      sat_hit = '0;
      for (int unsigned i = 0; i < NR_OF_BUTTONS_P; i++) begin
         req[i]     = (cnt[i] != '0);
         sat_hit[i] = press[i] && !take[i] && (cnt[i] == CNT_SAT);
      end
   end

   button_rr_arbiter #(
      .N_P    (NR_OF_BUTTONS_P),
      .ID_W_P (ID_WIDTH_P)
   ) u_arb (
      .req       (req),
      .rr_ptr    (rr_ptr),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_valid) state_nxt = OFFER;
         OFFER:   if (evt_valid && evt_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant     = (state == IDLE) && gnt_valid;
      handshake = (state == OFFER) && evt_valid && evt_ready;
      take      = '0;
      if (grant) take[gnt_id] = 1'b1;
   end

   // The granted counter restarts at 1 when a press lands in the grant cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_q     <= '0;
         ovf_flags <= '0;
         for (int unsigned i = 0; i < NR_OF_BUTTONS_P; i++) cnt[i] <= '0;
      end else begin
         tgl_q <= btn_tgl;
         for (int unsigned i = 0; i < NR_OF_BUTTONS_P; i++) begin
            if (take[i]) begin
               cnt[i] <= press[i] ? CNT_WIDTH_P'(1) : '0;
            end else if (press[i] && (cnt[i] != CNT_SAT)) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
            if (sat_hit[i]) begin
               ovf_flags[i] <= 1'b1;
            end else if (ovf_clr[i]) begin
               ovf_flags[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_count <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         evt_valid <= 1'b1;
         evt_id    <= gnt_id;
         evt_count <= cnt[gnt_id];
      end else if (handshake) begin
         evt_valid <= 1'b0;
         rr_ptr    <= ID_WIDTH_P'(rr_next(32'(evt_id), NR_OF_BUTTONS_P));
      end
   end

   assign irq = evt_valid;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench: directed vector table, hand sequences for corner cases,
// and a randomized phase compared every cycle against a behavioural model.
module tb_button_event_scheduler;

   localparam int NB   = 4;
   localparam int CW   = 2;
   localparam int CMAX = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_tgl, btn_mask, ovf_clr, ovf_flags;
   logic          evt_valid, evt_ready, irq;
   logic [1:0]    evt_id;
   logic [CW-1:0] evt_count;

   always #5 clk = ~clk;

   button_event_scheduler #(
      .NR_OF_BUTTONS_P (NB),
      .CNT_WIDTH_P     (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_tgl   (btn_tgl),
      .btn_mask  (btn_mask),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_count (evt_count),
      .ovf_flags (ovf_flags),
      .ovf_clr   (ovf_clr),
      .irq       (irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: pending press counts, offered event, fairness pointer.
   int            pend [NB];
   logic [NB-1:0] m_ovf, prev_tgl;
   logic          m_valid;
   int            m_id, m_cnt, m_rr;

   typedef struct {
      logic [NB-1:0] flip;
      logic          ready;
      logic          ev;
      int            eid;
      int            ecnt;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) pend[i] = 0;
      m_ovf = '0; prev_tgl = '0; m_valid = 1'b0;
      m_id = 0; m_cnt = 0; m_rr = 0;
   endtask

   task automatic model_step();
      logic [NB-1:0] p;
      int granted;
      int idx;
      logic sat;
      granted = -1;
      p = (btn_tgl ^ prev_tgl) & ~btn_mask;
      if (!m_valid) begin
         for (int k = 0; k < NB; k++) begin
            idx = (m_rr + k) % NB;
            if (granted < 0 && pend[idx] > 0) granted = idx;
         end
         if (granted >= 0) begin
            m_valid = 1'b1;
            m_id = granted;
            m_cnt = pend[granted];
            pend[granted] = p[granted] ? 1 : 0;
         end
      end else if (evt_ready) begin
         m_valid = 1'b0;
         m_rr = (m_id + 1) % NB;
      end
      for (int i = 0; i < NB; i++) begin
         sat = (i != granted) && p[i] && (pend[i] == CMAX);
         if (i != granted && p[i] && !sat) pend[i]++;
         if (sat) m_ovf[i] = 1'b1;
         else if (ovf_clr[i]) m_ovf[i] = 1'b0;
      end
      prev_tgl = btn_tgl;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("model_valid", evt_valid, m_valid);
      chk("model_irq", irq, m_valid);
      chk("model_id", evt_id, m_id);
      chk("model_count", evt_count, m_cnt);
      chk("model_ovf", ovf_flags, m_ovf);
   endtask

   task automatic expect_ev(input string nm, input logic v, input int id, input int c);
      chk({nm, "_valid"}, evt_valid, v);
      if (v) begin
         chk({nm, "_id"}, evt_id, id);
         chk({nm, "_count"}, evt_count, c);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn_tgl = '0; btn_mask = '0; ovf_clr = '0; evt_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", evt_valid, 0);
      chk("rst_id", evt_id, 0);
      chk("rst_count", evt_count, 0);
      chk("rst_ovf", ovf_flags, 0);
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic [NB-1:0] f, input logic r, input logic e,
                               input int id, input int c);
      vec_t v;
      v.flip = f; v.ready = r; v.ev = e; v.eid = id; v.ecnt = c;
      return v;
   endfunction

   initial begin
      tbl[0]  = mk(4'b1011, 1'b1, 1'b0, 0, 0);
      tbl[1]  = mk(4'b0000, 1'b1, 1'b1, 0, 1);
      tbl[2]  = mk(4'b0000, 1'b1, 1'b0, 0, 1);
      tbl[3]  = mk(4'b0000, 1'b1, 1'b1, 1, 1);
      tbl[4]  = mk(4'b0000, 1'b1, 1'b0, 1, 1);
      tbl[5]  = mk(4'b0000, 1'b1, 1'b1, 3, 1);
      tbl[6]  = mk(4'b0000, 1'b1, 1'b0, 3, 1);
      tbl[7]  = mk(4'b0011, 1'b1, 1'b0, 3, 1);
      tbl[8]  = mk(4'b0000, 1'b1, 1'b1, 0, 1);
      tbl[9]  = mk(4'b0000, 1'b1, 1'b0, 0, 1);
      tbl[10] = mk(4'b0000, 1'b1, 1'b1, 1, 1);
      tbl[11] = mk(4'b0000, 1'b1, 1'b0, 1, 1);
      tbl[12] = mk(4'b0100, 1'b1, 1'b0, 1, 1);
      tbl[13] = mk(4'b0000, 1'b1, 1'b1, 2, 1);
      tbl[14] = mk(4'b0000, 1'b1, 1'b0, 2, 1);
      tbl[15] = mk(4'b0000, 1'b1, 1'b0, 2, 1);

      do_reset();

      // Simultaneous presses, rr wrap, then single-press latency.
      for (int r = 0; r < 16; r++) begin
         btn_tgl   = btn_tgl ^ tbl[r].flip;
         evt_ready = tbl[r].ready;
         step();
         chk($sformatf("tbl%0d_valid", r), evt_valid, tbl[r].ev);
         chk($sformatf("tbl%0d_id", r), evt_id, tbl[r].eid);
         chk($sformatf("tbl%0d_count", r), evt_count, tbl[r].ecnt);
         chk($sformatf("tbl%0d_ovf", r), ovf_flags, 0);
      end

      // Coalesce under stall on button 1.
      evt_ready = 1'b0;
      btn_tgl[1] = ~btn_tgl[1]; step(); expect_ev("coal_pre", 1'b0, 0, 0);
      step(); expect_ev("coal_first", 1'b1, 1, 1);
      for (int k = 0; k < 3; k++) begin
         btn_tgl[1] = ~btn_tgl[1]; step(); expect_ev("coal_hold", 1'b1, 1, 1);
      end
      evt_ready = 1'b1;
      step(); expect_ev("coal_hs", 1'b0, 0, 0);
      step(); expect_ev("coal_second", 1'b1, 1, 3);
      step(); expect_ev("coal_hs2", 1'b0, 0, 0);

      // Press on button 0 landing in its own grant cycle.
      btn_tgl[0] = ~btn_tgl[0]; step(); expect_ev("gc_pre", 1'b0, 0, 0);
      btn_tgl[0] = ~btn_tgl[0]; step(); expect_ev("gc_event", 1'b1, 0, 1);
      step(); expect_ev("gc_hs", 1'b0, 0, 0);
      step(); expect_ev("gc_followup", 1'b1, 0, 1);
      step(); expect_ev("gc_hs2", 1'b0, 0, 0);
      step(); expect_ev("gc_idle", 1'b0, 0, 0);

      // Saturation and sticky overflow on button 3, stalled from reset.
      do_reset();
      evt_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         btn_tgl[3] = ~btn_tgl[3]; step();
      end
      expect_ev("sat_offer", 1'b1, 3, 1);
      chk("sat_ovf_set", ovf_flags, 4'b1000);
      ovf_clr = 4'b1000; step(); chk("sat_ovf_clr", ovf_flags, 0);
      btn_tgl[3] = ~btn_tgl[3]; step(); chk("sat_set_wins", ovf_flags, 4'b1000);
      ovf_clr = '0; step(); chk("sat_sticky", ovf_flags, 4'b1000);
      evt_ready = 1'b1;
      step(); expect_ev("sat_hs", 1'b0, 0, 0);
      step(); expect_ev("sat_pending", 1'b1, 3, 3);
      step(); expect_ev("sat_hs2", 1'b0, 0, 0);

      // Masked press is dropped; unmasking does not resurrect it.
      btn_mask = 4'b0100;
      btn_tgl[2] = ~btn_tgl[2];
      for (int k = 0; k < 3; k++) begin step(); expect_ev("mask_drop", 1'b0, 0, 0); end
      btn_mask = '0;
      for (int k = 0; k < 3; k++) begin step(); expect_ev("unmask_quiet", 1'b0, 0, 0); end

      // Asynchronous reset while an event is being offered.
      evt_ready = 1'b0;
      btn_tgl[1] = ~btn_tgl[1]; step();
      step(); expect_ev("rst_offer", 1'b1, 1, 1);
      chk("rst_ovf_before", ovf_flags, 4'b1000);
      rst_n = 1'b0;
      btn_tgl = '0;
      #1;
      chk("async_valid", evt_valid, 0);
      chk("async_irq", irq, 0);
      chk("async_count", evt_count, 0);
      chk("async_ovf", ovf_flags, 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      evt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin step(); expect_ev("post_rst", 1'b0, 0, 0); end

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         btn_tgl   = btn_tgl ^ NB'($urandom & $urandom);
         evt_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
         if ($urandom_range(0, 31) == 0) btn_mask = NB'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Collects press toggles from the four button cores and turns them into press events.
- Counts pending presses per button and coalesces repeats.
- Round-robin arbitrates the buttons onto one valid/ready event stream, with id and press count, for the PS register/IRQ interface.
- Provides per-button masking and sticky overflow flags for software.

Parameters:
- NR_OF_BUTTONS_P, 4: number of button toggle inputs, >= 2.
- CNT_WIDTH_P, 8: width of each per-button pending-press counter and of evt_count.
- ID_WIDTH_P, $clog2(NR_OF_BUTTONS_P): width of evt_id (derived, do not override).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_tgl  input  NR_OF_BUTTONS_P  toggle outputs of the button cores; each change = one press
- btn_mask  input  NR_OF_BUTTONS_P  1 = ignore presses on that button
- evt_valid  output  1  event offered
- evt_ready  input  1  consumer accepts event
- evt_id  output  ID_WIDTH_P  index of the button being offered
- evt_count  output  CNT_WIDTH_P  presses coalesced into this event, >= 1
- ovf_flags  output  NR_OF_BUTTONS_P  sticky: a counter saturated and presses were lost
- ovf_clr  input  NR_OF_BUTTONS_P  one-cycle pulse mask clearing ovf_flags bits
- irq  output  1  equals evt_valid

Behaviour:
- Reset (async assert, sync release):
  - tgl_q = 0; all cnt = 0; ovf_flags = 0.
  - state = IDLE; evt_valid = 0; evt_id = 0; evt_count = 0; rr pointer = 0.
- Press detect:
  - press[i] = (btn_tgl[i] ^ tgl_q[i]) & ~btn_mask[i].
  - tgl_q <= btn_tgl every cycle, including for masked buttons, so unmasking never creates a phantom press.
- Counter per button:
  - On press[i] at an edge, cnt[i] <= cnt[i] + 1.
  - At 2^CNT_WIDTH_P-1 the counter holds, and ovf_flags[i] <= 1 if press[i].
  - On the same edge, ovf_clr[i] with a saturating press[i]: set wins.
- FSM states IDLE and OFFER.
- IDLE:
  - If any cnt != 0, select the first non-zero index searching from rr_ptr upward, wrapping.
  - Load evt_id = sel and evt_count = cnt[sel]; set evt_valid <= 1; go to OFFER.
  - cnt[sel] <= press[sel] ? 1 : 0, so a press in the grant cycle is never lost.
- OFFER:
  - evt_valid, evt_id and evt_count are held stable until evt_valid & evt_ready at an edge.
  - On that handshake: evt_valid <= 0, rr_ptr <= evt_id + 1 (wraps to 0 after NR_OF_BUTTONS_P-1), go to IDLE.
  - evt_ready is ignored while evt_valid = 0.
  - Presses during OFFER keep accumulating, including on the offered button.
- Latency:
  - btn_tgl change before edge k: cnt updates at k, evt_valid is high after edge k+1 (2 cycles).
  - Back-to-back events have one idle cycle between handshake and next evt_valid, so max throughput is 1 event per 2 cycles.
- Masking: btn_mask only gates new presses; already-pending counts are still offered.
- Async reset mid-OFFER: the event is dropped and all counts are discarded.
- irq is combinationally equal to the evt_valid register (glitch-free).

Decomposition:
- Package button_scheduler_pkg holds:
  - typedef enum logic {IDLE, OFFER} sched_state_t
  - localparam CNT_MAX_C
  - helper function rr_next(ptr, N)
- Sub-module button_rr_arbiter: combinational rotate-priority select.
  - Inputs: req vector (cnt != 0), rr_ptr.
  - Outputs: gnt_valid, gnt_id.
- Counters, FSM and output registers stay in button_event_scheduler.

Test Plan:
- Single press: toggle btn_tgl[2] once, evt_ready = 1 -> evt_valid high 2 cycles later with evt_id = 2, evt_count = 1; handshake; evt_valid = 0 afterwards, cnt[2] = 0.
- Simultaneous: toggle bits 0, 1 and 3 on the same cycle, evt_ready = 1 -> events in order id 0, 1, 3, each count = 1. Then toggle 0 and 1 together -> order 0, 1 (rr_ptr wrapped to 0 after id 3).
- Coalesce under stall: evt_ready = 0 while btn 1 presses 3 times after its first event is offered -> first event holds id 1, count 1, stable. After handshake -> second event id 1, count 3.
- Grant-cycle press: toggle btn 0 exactly in the IDLE grant cycle -> current event count = N, and a follow-up event with count = 1.
- Saturation with CNT_WIDTH_P = 2 and evt_ready = 0 from reset:
  - 5 presses on btn 3 -> count 3, ovf_flags = 4'b1000.
  - ovf_clr = 4'b1000 pulse -> 0.
  - Clear and saturating press on the same cycle -> flag stays 1.
- Mask and reset: btn_mask[2] = 1, toggle btn 2 -> no event; unmask -> still no event. Assert rst_n low during OFFER -> evt_valid, evt_count and ovf_flags = 0 immediately; no event after release.
